// File: rtl/insn_fetch_stage.sv
// insn_fetch_stage: PC issue into synchronous imem, one-entry skid buffer and F/D register.
// Holds fetched words across decode stalls; execute redirects flush the stage.
module insn_fetch_stage #(
   parameter int          ADDR_W   = 12,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_q,
   output logic [31:0]       fd_insn,
   output logic [31:0]       fd_pc,
   output logic              fd_valid,
   output logic [4:0]        fd_opcode
);
   logic [31:0] pc_q, pc_d, f_pc_q, f_pc_d, sk_insn_q, sk_insn_d, sk_pc_q, sk_pc_d;
   logic [31:0] fd_insn_q, fd_insn_d, fd_pc_q, fd_pc_d;
   logic        f_valid_q, f_valid_d, sk_valid_q, sk_valid_d, fd_valid_q, fd_valid_d;

   always_comb begin
      pc_d       = pc_q;
      f_pc_d     = f_pc_q;
      f_valid_d  = f_valid_q;
      sk_valid_d = sk_valid_q;
      sk_insn_d  = sk_insn_q;
      sk_pc_d    = sk_pc_q;
      fd_insn_d  = fd_insn_q;
      fd_pc_d    = fd_pc_q;
      fd_valid_d = fd_valid_q;
      if (redirect) begin
         pc_d       = redirect_pc;
         f_valid_d  = 1'b0;
         sk_valid_d = 1'b0;
         fd_valid_d = 1'b0;
         fd_insn_d  = '0;
         fd_pc_d    = '0;
      end else if (stall) begin
         // the word returning this cycle would be lost on the next edge, so park it
         if (f_valid_q && !sk_valid_q) begin
            sk_insn_d  = imem_q;
            sk_pc_d    = f_pc_q;
            sk_valid_d = 1'b1;
         end
         f_valid_d = 1'b0;
      end else begin
         if (sk_valid_q) begin
            fd_insn_d  = sk_insn_q;
            fd_pc_d    = sk_pc_q;
            fd_valid_d = 1'b1;
         end else if (f_valid_q) begin
            fd_insn_d  = imem_q;
            fd_pc_d    = f_pc_q;
            fd_valid_d = 1'b1;
         end else begin
            fd_insn_d  = '0;
            fd_valid_d = 1'b0;
         end
         sk_valid_d = 1'b0;
         f_pc_d     = pc_q;
         f_valid_d  = 1'b1;
         pc_d       = pc_q + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q       <= RESET_PC;
         f_pc_q     <= '0;
         f_valid_q  <= 1'b0;
         sk_valid_q <= 1'b0;
         sk_insn_q  <= '0;
         sk_pc_q    <= '0;
         fd_insn_q  <= '0;
         fd_pc_q    <= '0;
         fd_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         f_pc_q     <= f_pc_d;
         f_valid_q  <= f_valid_d;
         sk_valid_q <= sk_valid_d;
         sk_insn_q  <= sk_insn_d;
         sk_pc_q    <= sk_pc_d;
         fd_insn_q  <= fd_insn_d;
         fd_pc_q    <= fd_pc_d;
         fd_valid_q <= fd_valid_d;
      end
   end

   assign imem_addr = pc_q[ADDR_W-1:0];
   assign fd_insn   = fd_insn_q;
   assign fd_pc     = fd_pc_q;
   assign fd_valid  = fd_valid_q;
   assign fd_opcode = fd_insn_q[31:27];
endmodule
